// File: rtl/layer_sequencer_if.sv
// Host/config, Issue and writeback-drain signals of the layer sequencer.
// master = environment side, slave = sequencer side.
interface layer_sequencer_if #(
  parameter int num_layers = 8
);
  localparam int LW = (num_layers > 1) ? $clog2(num_layers) : 1;

  logic [LW-1:0] cfg_write_addr;
  logic [21:0]   cfg_write_data;
  logic          cfg_write_en;
  logic [LW:0]   layer_count;
  logic          start;
  logic [7:0]    issue_image_dim;
  logic [8:0]    issue_image_depth;
  logic [1:0]    issue_filter_halfsize;
  logic [2:0]    issue_filter_stride;
  logic          issue_rst;
  logic          issue_done;
  logic          drain_req;
  logic          drain_ack;
  logic [LW-1:0] current_layer;
  logic          busy;
  logic          done;

  modport master (
    output cfg_write_addr, cfg_write_data, cfg_write_en,
    output layer_count, start, issue_done, drain_ack,
    input  issue_image_dim, issue_image_depth,
    input  issue_filter_halfsize, issue_filter_stride,
    input  issue_rst, drain_req, current_layer, busy, done
  );

  modport slave (
    input  cfg_write_addr, cfg_write_data, cfg_write_en,
    input  layer_count, start, issue_done, drain_ack,
    output issue_image_dim, issue_image_depth,
    output issue_filter_halfsize, issue_filter_stride,
    output issue_rst, drain_req, current_layer, busy, done
  );
endinterface

// File: rtl/layer_sequencer.sv
// Steps the Issue unit through a programmed descriptor table,
// one layer at a time: load config, release Issue, wait, drain.
module layer_sequencer #(
  parameter int num_layers = 8
) (
  input logic              clk,
  input logic              rst,
  layer_sequencer_if.slave bus
);

  localparam int LW = (num_layers > 1) ? $clog2(num_layers) : 1;
  localparam logic [LW:0] NL  = (LW+1)'(num_layers);
  localparam logic [LW:0] ONE = (LW+1)'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [21:0] tbl_q [num_layers];

  logic [2:0]    state_q, state_d;
  logic [LW:0]   count_q, count_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [21:0]   cfg_q, cfg_d;
  logic          irst_q, irst_d;
  logic          dreq_q, dreq_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [LW:0] lc_sat;
  logic        last_layer;

  assign lc_sat = (bus.layer_count > NL) ? NL : bus.layer_count;
  assign last_layer = ({1'b0, layer_q} == (count_q - ONE));

  // No reset: descriptors survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (bus.cfg_write_en) begin
      tbl_q[bus.cfg_write_addr] <= bus.cfg_write_data;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    layer_d = layer_q;
    cfg_d   = cfg_q;
    irst_d  = irst_q;
    dreq_d  = dreq_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (bus.start) begin
          count_d = lc_sat;
          if (lc_sat == '0) begin
            done_d = 1'b1;
          end else begin
            layer_d = '0;
            state_d = S_LOAD;
          end
        end
      end
      (state_q == S_LOAD): begin
        cfg_d   = tbl_q[layer_q];
        state_d = S_ARM;
      end
      (state_q == S_ARM): begin
        irst_d  = 1'b0;
        state_d = S_RUN;
      end
      (state_q == S_RUN): begin
        if (bus.issue_done) begin
          irst_d  = 1'b1;
          dreq_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      (state_q == S_DRAIN): begin
        if (bus.drain_ack) begin
          dreq_d = 1'b0;
          if (last_layer) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            layer_d = layer_q + LW'(1);
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        irst_d  = 1'b1;
        dreq_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      layer_q <= '0;
      cfg_q   <= '0;
      irst_q  <= 1'b1;
      dreq_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      layer_q <= layer_d;
      cfg_q   <= cfg_d;
      irst_q  <= irst_d;
      dreq_q  <= dreq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.issue_image_dim       = cfg_q[21:14];
  assign bus.issue_image_depth     = cfg_q[13:5];
  assign bus.issue_filter_halfsize = cfg_q[4:3];
  assign bus.issue_filter_stride   = cfg_q[2:0];
  assign bus.issue_rst             = irst_q;
  assign bus.drain_req             = dreq_q;
  assign bus.current_layer         = layer_q;
  assign bus.busy                  = busy_q;
  assign bus.done                  = done_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: cycle table plus
// hand-written multi-layer sequences.
module tb_layer_sequencer;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_tot;

  layer_sequencer_if #(.num_layers(8)) bus();

  layer_sequencer #(.num_layers(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] lc;
    logic       idn;
    logic       ack;
    logic       e_irst;
    logic       e_dreq;
    logic       e_busy;
    logic       e_done;
    logic [2:0] e_layer;
  } vec_t;

  vec_t vt [20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [21:0] mk(input int dim, input int dep,
                                     input int hs, input int st);
    logic [7:0] d8;
    logic [8:0] p9;
    logic [1:0] h2;
    logic [2:0] s3;
    d8 = dim[7:0];
    p9 = dep[8:0];
    h2 = hs[1:0];
    s3 = st[2:0];
    return {d8, p9, h2, s3};
  endfunction

  function automatic logic [21:0] cfg_out();
    return {bus.issue_image_dim, bus.issue_image_depth,
            bus.issue_filter_halfsize, bus.issue_filter_stride};
  endfunction

  task automatic wr_cfg(input int a, input logic [21:0] d);
    bus.cfg_write_en   = 1'b1;
    bus.cfg_write_addr = a[2:0];
    bus.cfg_write_data = d;
    step();
    bus.cfg_write_en   = 1'b0;
  endtask

  task automatic go(input int lc);
    bus.layer_count = lc[3:0];
    bus.start       = 1'b1;
    step();
    bus.start       = 1'b0;
  endtask

  // Entry: just after the edge that put the sequencer in LOAD.
  task automatic run_layer(input int idx, input logic [21:0] cfg,
                           input bit last, input int rc,
                           input bit inj, input bit wr,
                           input logic [21:0] wd);
    bit stay;
    chk("load_irst", bus.issue_rst, 1);
    chk("load_layer", bus.current_layer, idx);
    chk("load_busy", bus.busy, 1);
    if (wr) begin
      bus.cfg_write_en   = 1'b1;
      bus.cfg_write_addr = idx[2:0];
      bus.cfg_write_data = wd;
    end
    step();
    bus.cfg_write_en = 1'b0;
    chk("arm_cfg", cfg_out(), cfg);
    chk("arm_irst", bus.issue_rst, 1);
    step();
    chk("run_irst", bus.issue_rst, 0);
    stay = 1'b1;
    for (int c = 1; c < rc; c++) begin
      if (inj && c == 2) begin
        bus.start     = 1'b1;
        bus.drain_ack = 1'b1;
      end
      step();
      bus.start     = 1'b0;
      bus.drain_ack = 1'b0;
      if (bus.issue_rst !== 1'b0 || bus.drain_req !== 1'b0 ||
          bus.current_layer !== idx[2:0])
        stay = 1'b0;
    end
    chk("run_hold", stay, 1);
    bus.issue_done = 1'b1;
    step();
    bus.issue_done = 1'b0;
    chk("drain_irst", bus.issue_rst, 1);
    chk("drain_req", bus.drain_req, 1);
    step();
    step();
    chk("drain_wait", bus.drain_req, 1);
    bus.drain_ack = 1'b1;
    step();
    bus.drain_ack = 1'b0;
    chk("ack_dreq", bus.drain_req, 0);
    if (last) begin
      chk("end_done", bus.done, 1);
      chk("end_busy", bus.busy, 0);
      chk("end_cfg_hold", cfg_out(), cfg);
      step();
      chk("end_done_pulse", bus.done, 0);
      chk("end_irst", bus.issue_rst, 1);
    end else begin
      chk("next_done", bus.done, 0);
      chk("next_layer", bus.current_layer, idx + 1);
    end
  endtask

  logic [21:0] cfg_a, cfg_b, x0, x1, y1;
  logic [21:0] big [8];

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst = 1'b1;
    bus.cfg_write_addr = '0;
    bus.cfg_write_data = '0;
    bus.cfg_write_en   = 1'b0;
    bus.layer_count    = '0;
    bus.start          = 1'b0;
    bus.issue_done     = 1'b0;
    bus.drain_ack      = 1'b0;
    step();
    step();
    chk("rst_irst", bus.issue_rst, 1);
    chk("rst_dreq", bus.drain_req, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_layer", bus.current_layer, 0);
    chk("rst_cfg", cfg_out(), 0);
    rst = 1'b0;

    cfg_a = mk(32, 3, 1, 1);
    cfg_b = mk(16, 8, 2, 2);
    wr_cfg(0, cfg_a);
    wr_cfg(1, cfg_b);

    // rst start lc idn ack | irst dreq busy done layer
    vt[0]  = '{0, 1, 0, 0, 0, 1, 0, 0, 1, 0};
    vt[1]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vt[2]  = '{0, 1, 2, 0, 0, 1, 0, 1, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 0};
    vt[4]  = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    vt[5]  = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    vt[6]  = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 0};
    vt[7]  = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 1};
    vt[9]  = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
    vt[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    vt[11] = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 1};
    vt[12] = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    vt[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vt[14] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 0};
    vt[15] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    vt[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vt[17] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    vt[18] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
    vt[19] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

    for (int i = 0; i < 20; i++) begin
      rst             = vt[i].rst;
      bus.start       = vt[i].start;
      bus.layer_count = vt[i].lc;
      bus.issue_done  = vt[i].idn;
      bus.drain_ack   = vt[i].ack;
      step();
      chk($sformatf("vec%0d_irst", i), bus.issue_rst, vt[i].e_irst);
      chk($sformatf("vec%0d_dreq", i), bus.drain_req, vt[i].e_dreq);
      chk($sformatf("vec%0d_busy", i), bus.busy, vt[i].e_busy);
      chk($sformatf("vec%0d_done", i), bus.done, vt[i].e_done);
      chk($sformatf("vec%0d_layer", i), bus.current_layer,
          vt[i].e_layer);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    bus.issue_done = 1'b0;
    bus.drain_ack = 1'b0;

    // Two-layer run with start/ack noise during RUN of layer 0.
    go(2);
    run_layer(0, cfg_a, 0, 10, 1, 0, '0);
    run_layer(1, cfg_b, 1, 10, 0, 0, '0);

    // Oversized layer_count saturates at the table depth.
    for (int i = 0; i < 8; i++) begin
      big[i] = mk(10 + i, 20 + 3 * i, i % 4, (i + 1) % 8);
      wr_cfg(i, big[i]);
    end
    go(12);
    for (int i = 0; i < 8; i++)
      run_layer(i, big[i], i == 7, 3, 0, 0, '0);
    chk("sat_idle_busy", bus.busy, 0);

    // Write racing the LOAD of the same entry sees old data.
    x0 = mk(64, 1, 0, 1);
    x1 = mk(8, 100, 3, 4);
    y1 = mk(200, 511, 2, 7);
    wr_cfg(0, x0);
    wr_cfg(1, x1);
    go(2);
    run_layer(0, x0, 0, 4, 0, 0, '0);
    run_layer(1, x1, 1, 4, 0, 1, y1);
    go(2);
    run_layer(0, x0, 0, 4, 0, 0, '0);
    run_layer(1, y1, 1, 4, 0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
